speed_sel: RTL and testbench

//   Upstream of the speed-selectable tick timer. Produces the 2-bit spe code that sets that timer's rate.

---
 rtl/speed_sel_pkg.sv | 17 +
 rtl/speed_sel_if.sv | 16 +
 rtl/speed_sel_btn_debounce.sv | 53 +++++
 rtl/speed_sel.sv | 62 ++++++
 tb/tb_speed_sel.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/speed_sel_pkg.sv
// Shared speed codes and defaults for speed_sel and the downstream tick timer.
package speed_sel_pkg;

  localparam int unsigned SPE_W = 2;
  typedef logic [SPE_W-1:0] spe_t;

  localparam spe_t SPE_1HZ = 2'b00;
  localparam spe_t SPE_2HZ = 2'b01;
  localparam spe_t SPE_4HZ = 2'b10;
  localparam spe_t SPE_8HZ = 2'b11;
  localparam spe_t SPE_MIN = SPE_1HZ;
  localparam spe_t SPE_MAX = SPE_8HZ;

  // 10 ms at 50 MHz
  localparam int unsigned DEB_CYCLES_DEF = 500000;

endpackage

// File: rtl/speed_sel_if.sv
// Button inputs and speed outputs of speed_sel.
interface speed_sel_if;
  import speed_sel_pkg::*;

  logic btn_up;
  logic btn_dn;
  spe_t spe;
  logic spe_chg;
  logic at_max;
  logic at_min;

  modport master (output btn_up, output btn_dn,
                  input spe, input spe_chg, input at_max, input at_min);
  modport slave  (input btn_up, input btn_dn,
                  output spe, output spe_chg, output at_max, output at_min);
endinterface

// File: rtl/speed_sel_btn_debounce.sv
// One push-button: 2-FF synchroniser, stable-window debounce, press pulse on clean 0->1.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = speed_sel_pkg::DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);
  localparam int unsigned CNT_W = $clog2(DEB_CYCLES);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             stable_dly_q;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any sample that agrees with the debounced level restarts the window.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    // Pulse is registered one edge after the debounced level rises.
    press_d = stable_q & ~stable_dly_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
      press_q      <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/speed_sel.sv
// Debounced faster/slower buttons step a saturating 2-bit speed code for the tick timer.
module speed_sel
  import speed_sel_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter spe_t        SPE_INIT   = SPE_1HZ
) (
  input  logic        clk,
  input  logic        rst_n,
  speed_sel_if.slave  bus
);
  logic up_press, dn_press;
  spe_t spe_q, spe_d;
  logic spe_chg_q, spe_chg_d;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (bus.btn_up),
    .press_o (up_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (bus.btn_dn),
    .press_o (dn_press)
  );

  // Simultaneous presses cancel; saturated presses neither move spe nor pulse spe_chg.
  always_comb begin
    spe_d     = spe_q;
    spe_chg_d = 1'b0;
    unique case ({up_press, dn_press})
      2'b10: if (spe_q != SPE_MAX) begin
        spe_d     = spe_q + SPE_W'(1);
        spe_chg_d = 1'b1;
      end
      2'b01: if (spe_q != SPE_MIN) begin
        spe_d     = spe_q - SPE_W'(1);
        spe_chg_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spe_q     <= SPE_INIT;
      spe_chg_q <= 1'b0;
    end else begin
      spe_q     <= spe_d;
      spe_chg_q <= spe_chg_d;
    end
  end

  assign bus.spe     = spe_q;
  assign bus.spe_chg = spe_chg_q;
  assign bus.at_max  = (spe_q == SPE_MAX);
  assign bus.at_min  = (spe_q == SPE_MIN);

endmodule

// File: tb/tb_speed_sel.sv
// Bench for speed_sel: directed scenarios plus randomized button traffic against a reference model.
module tb_speed_sel;
  localparam int unsigned DEB = 4;

  logic clk;
  logic rst_n;
  int   vectors;
  int   errors;

  speed_sel_if bus ();

  speed_sel #(.DEB_CYCLES(DEB), .SPE_INIT(2'b00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a button level is accepted after DEB consecutive
  // disagreeing synchronised samples; an accepted rise moves spe two edges later.
  int   m_run [2];
  logic m_p1 [2];
  logic m_p2 [2];
  logic m_stab [2];
  logic m_r1 [2];
  logic m_r2 [2];
  int   m_spe;
  logic m_chg;

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_run[b] = 0; m_p1[b] = 1'b0; m_p2[b] = 1'b0;
      m_stab[b] = 1'b0; m_r1[b] = 1'b0; m_r2[b] = 1'b0;
    end
    m_spe = 0;
    m_chg = 1'b0;
  endtask

  task automatic model_step();
    logic raw [2];
    logic s;
    raw[0] = bus.btn_up;
    raw[1] = bus.btn_dn;
    if (!rst_n) begin
      model_reset();
    end else begin
      m_chg = 1'b0;
      if (m_r2[0] && !m_r2[1] && m_spe < 3) begin
        m_spe = m_spe + 1; m_chg = 1'b1;
      end else if (m_r2[1] && !m_r2[0] && m_spe > 0) begin
        m_spe = m_spe - 1; m_chg = 1'b1;
      end
      for (int b = 0; b < 2; b++) begin
        m_r2[b] = m_r1[b];
        s       = m_p2[b];
        m_p2[b] = m_p1[b];
        m_p1[b] = raw[b];
        m_r1[b] = 1'b0;
        if (s != m_stab[b]) begin
          m_run[b] = m_run[b] + 1;
          if (m_run[b] == int'(DEB)) begin
            m_stab[b] = s;
            m_run[b]  = 0;
            m_r1[b]   = s;
          end
        end else begin
          m_run[b] = 0;
        end
      end
    end
  endtask

  // {spe, spe_chg, at_max, at_min}
  function automatic logic [4:0] exp_vec(input int spe, input logic chg);
    logic [1:0] s;
    s = 2'(spe);
    return {s, chg, (s == 2'b11), (s == 2'b00)};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [4:0] got;
    rst_n = 1'b1; bus.btn_up = 1'b0; bus.btn_dn = 1'b0;
    #3 rst_n = 1'b0;
    model_reset();
    #1 got = {bus.spe, bus.spe_chg, bus.at_max, bus.at_min};
    vectors++;
    if (got !== exp_vec(0, 1'b0)) begin
      errors++; $display("FAIL reset_init: got %b want %b", got, exp_vec(0, 1'b0));
    end
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_clean_up();
    logic [4:0] got, exp;
    bus.btn_up = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      tick();
      if (i == 12) bus.btn_up = 1'b0;
      exp = exp_vec((i >= 8) ? 1 : 0, (i == 8));
      got = {bus.spe, bus.spe_chg, bus.at_max, bus.at_min};
      vectors++;
      if (got !== exp) begin
        errors++; $display("FAIL clean_up cycle %0d: got %b want %b", i, got, exp);
      end
    end
  endtask

  task automatic test_bounce();
    logic [4:0] got;
    apply_reset();
    for (int i = 0; i < 26; i++) begin
      bus.btn_up = (i < 16) ? ((i % 4) < 2) : 1'b0;
      tick();
      got = {bus.spe, bus.spe_chg, bus.at_max, bus.at_min};
      vectors++;
      if (got !== exp_vec(0, 1'b0)) begin
        errors++; $display("FAIL bounce cycle %0d: got %b want %b", i, got, exp_vec(0, 1'b0));
      end
    end
  endtask

  task automatic test_saturation();
    int pulses;
    int want [8] = '{1, 2, 3, 3, 2, 1, 0, 0};
    logic [4:0] got;
    apply_reset();
    pulses = 0;
    for (int p = 0; p < 8; p++) begin
      if (p < 4) bus.btn_up = 1'b1; else bus.btn_dn = 1'b1;
      for (int i = 1; i <= 16; i++) begin
        tick();
        if (i == 8) begin bus.btn_up = 1'b0; bus.btn_dn = 1'b0; end
        if (bus.spe_chg === 1'b1) pulses++;
      end
      got = {bus.spe, bus.spe_chg, bus.at_max, bus.at_min};
      vectors++;
      if (got !== exp_vec(want[p], 1'b0)) begin
        errors++; $display("FAIL saturation press %0d: got %b want %b", p, got, exp_vec(want[p], 1'b0));
      end
      if (p == 3) begin
        vectors++;
        if (pulses !== 3) begin
          errors++; $display("FAIL saturation up_pulses: got %0d want 3", pulses);
        end
        pulses = 0;
      end
    end
    vectors++;
    if (pulses !== 3) begin
      errors++; $display("FAIL saturation dn_pulses: got %0d want 3", pulses);
    end
  endtask

  task automatic test_simultaneous();
    int pulses;
    logic [4:0] got;
    apply_reset();
    bus.btn_up = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 8) bus.btn_up = 1'b0;
    end
    bus.btn_up = 1'b1; bus.btn_dn = 1'b1;
    for (int i = 1; i <= 26; i++) begin
      tick();
      if (i == 14) begin bus.btn_up = 1'b0; bus.btn_dn = 1'b0; end
      got = {bus.spe, bus.spe_chg, bus.at_max, bus.at_min};
      vectors++;
      if (got !== exp_vec(1, 1'b0)) begin
        errors++; $display("FAIL simultaneous cycle %0d: got %b want %b", i, got, exp_vec(1, 1'b0));
      end
    end
    pulses = 0;
    bus.btn_up = 1'b1;
    for (int i = 1; i <= 36; i++) begin
      tick();
      if (bus.spe_chg === 1'b1) pulses++;
      if (i == 10) bus.btn_dn = 1'b1;
      if (i == 12) begin
        vectors++;
        if (bus.spe !== 2'b10) begin
          errors++; $display("FAIL skewed_mid spe: got %b want 10", bus.spe);
        end
      end
      if (i == 26) begin bus.btn_up = 1'b0; bus.btn_dn = 1'b0; end
    end
    vectors++;
    if (bus.spe !== 2'b01 || pulses !== 2) begin
      errors++; $display("FAIL skewed_end: got spe %b pulses %0d want spe 01 pulses 2", bus.spe, pulses);
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] got;
    #2 rst_n = 1'b0;
    model_reset();
    #1 got = {bus.spe, bus.spe_chg, bus.at_max, bus.at_min};
    vectors++;
    if (got !== exp_vec(0, 1'b0)) begin
      errors++; $display("FAIL async_reset: got %b want %b", got, exp_vec(0, 1'b0));
    end
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_debounce();
    logic [4:0] got, exp;
    apply_reset();
    bus.btn_up = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      tick();
      got = {bus.spe, bus.spe_chg, bus.at_max, bus.at_min};
      vectors++;
      if (got !== exp_vec(0, 1'b0)) begin
        errors++; $display("FAIL mid_reset_hold: got %b want %b", got, exp_vec(0, 1'b0));
      end
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp = exp_vec((i >= 8) ? 1 : 0, (i == 8));
      got = {bus.spe, bus.spe_chg, bus.at_max, bus.at_min};
      vectors++;
      if (got !== exp) begin
        errors++; $display("FAIL mid_reset_release cycle %0d: got %b want %b", i, got, exp);
      end
    end
    bus.btn_up = 1'b0;
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_random();
    int run_up, run_dn;
    logic [4:0] got, exp;
    apply_reset();
    run_up = 0; run_dn = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run_up == 0) begin bus.btn_up = 1'($urandom_range(0, 1)); run_up = $urandom_range(1, 12); end
      if (run_dn == 0) begin bus.btn_dn = 1'($urandom_range(0, 1)); run_dn = $urandom_range(1, 12); end
      run_up--; run_dn--;
      tick();
      exp = exp_vec(m_spe, m_chg);
      got = {bus.spe, bus.spe_chg, bus.at_max, bus.at_min};
      vectors++;
      if (got !== exp) begin
        errors++; $display("FAIL random cycle %0d: got %b want %b", i, got, exp);
      end
    end
    bus.btn_up = 1'b0; bus.btn_dn = 1'b0;
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    model_reset();
    test_reset();
    test_clean_up();
    test_bounce();
    test_saturation();
    test_simultaneous();
    test_async_reset();
    test_reset_mid_debounce();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
